// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : instr_fetch_unit_pkg                                          |
// | Brief  : Shared types and constants for the RV32I instruction fetch.   |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
package instr_fetch_unit_pkg;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_OUT  = 3'd3,
        ST_DROP = 3'd4
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : instr_fetch_unit_if                                           |
// | Brief  : Imem request/response, decode handoff and redirect signals.   |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic [ADDR_W-1:0] instr_pc_plus4;
    logic              pc_src;
    logic [ADDR_W-1:0] pc_target;

    // master: the fetch unit; slave: imem + decode + redirect source
    modport master (
        output imem_req_valid, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, pc_src, pc_target
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, pc_src, pc_target
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : instr_fetch_unit                                              |
// | Brief  : PC owner; one outstanding imem fetch, one instruction to      |
// |          decode at a time, redirect via pc_src/pc_target.              |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  fetch
);

    fetch_state_e      r_state,    w_next_state;
    logic [ADDR_W-1:0] r_pc,       w_next_pc;
    logic [DATA_W-1:0] r_instr,    w_next_instr;
    logic [ADDR_W-1:0] r_instr_pc, w_next_instr_pc;
    logic              w_req_valid;
    logic              w_instr_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_next_pc;
            r_instr    <= w_next_instr;
            r_instr_pc <= w_next_instr_pc;
        end
    end

    // A redirect always loads the PC, whatever the state; states only pick the next state.
    always_comb begin
        w_next_state    = r_state;
        w_next_pc       = fetch.pc_src ? fetch.pc_target : r_pc;
        w_next_instr    = r_instr;
        w_next_instr_pc = r_instr_pc;
        w_req_valid     = 1'b0;
        w_instr_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_REQ;
            end
            ST_REQ: begin
                w_req_valid = 1'b1;
                if (fetch.imem_req_ready) begin
                    w_next_state = fetch.pc_src ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fetch.pc_src) begin
                    w_next_state = fetch.imem_rsp_valid ? ST_REQ : ST_DROP;
                end else if (fetch.imem_rsp_valid) begin
                    w_next_instr    = fetch.imem_rsp_data;
                    w_next_instr_pc = r_pc;
                    w_next_state    = ST_OUT;
                end
            end
            ST_OUT: begin
                w_instr_valid = 1'b1;
                if (fetch.pc_src) begin
                    w_next_state = ST_REQ;
                end else if (fetch.instr_ready) begin
                    w_next_pc    = r_pc + ADDR_W'(INSTR_BYTES);
                    w_next_state = ST_REQ;
                end
            end
            ST_DROP: begin
                if (fetch.imem_rsp_valid) begin
                    w_next_state = ST_REQ;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign fetch.imem_req_valid = w_req_valid;
    assign fetch.imem_addr      = r_pc;
    assign fetch.instr_valid    = w_instr_valid;
    assign fetch.instr          = r_instr;
    assign fetch.instr_pc       = r_instr_pc;
    assign fetch.instr_pc_plus4 = r_instr_pc + ADDR_W'(INSTR_BYTES);

    // A response is only legal while a fetch is outstanding.
    a_rsp_only_when_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n)
        fetch.imem_rsp_valid |-> (r_state == ST_WAIT || r_state == ST_DROP)
    );

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_instr_fetch_unit                                           |
// | Brief  : Directed self-checking bench with imem model and scoreboard.  |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    int   lat = 1;
    int   fetch_cyc = 0;
    int   instr_cyc = 0;
    logic [31:0] sb[$];

    instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    instr_fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fetch (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0013;
    endfunction

    // Imem model: handshake sampled just before the rising edge, response
    // presented on the falling edge 'lat' cycles after the accepting edge.
    logic        hs = 1'b0;
    logic [31:0] hs_addr = '0;
    int          hs_lat = 1;
    int          pend = 0;
    logic [31:0] pend_addr = '0;
    always begin
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        if (!rst_n) begin
            pend = 0;
            hs   = 1'b0;
        end else begin
            if (hs) begin
                pend      = hs_lat;
                pend_addr = hs_addr;
            end
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = mem_word(pend_addr);
                end
            end
        end
        #4;
        hs      = rst_n && bus.imem_req_valid && bus.imem_req_ready;
        hs_addr = bus.imem_addr;
        hs_lat  = lat;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_fetch(input logic [31:0] exp_addr);
        int n = 0;
        while (!bus.imem_req_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        chk("fetch_addr", bus.imem_addr, exp_addr);
        fetch_cyc = cyc;
    endtask

    task automatic wait_instr();
        int n = 0;
        logic [31:0] e;
        while (!bus.instr_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("instr_valid", {31'b0, bus.instr_valid}, 32'd1);
        if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $error("FAIL sb_empty: observed instr_pc %h expected none", bus.instr_pc);
        end else begin
            e = sb.pop_front();
            chk("instr_pc", bus.instr_pc, e);
            chk("instr_word", bus.instr, mem_word(e));
            chk("instr_pc_plus4", bus.instr_pc_plus4, e + 32'd4);
        end
        instr_cyc = cyc;
        @(negedge clk);
    endtask

    initial begin
        int t_first;
        logic [31:0] held_instr;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b0;
        bus.pc_src         = 1'b0;
        bus.pc_target      = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        chk("rst_instr_pc", bus.instr_pc, 32'h0);
        chk("rst_instr", bus.instr, 32'h0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        wait_fetch(32'h0);

        // Zero-wait stream, latency and throughput
        bus.instr_ready = 1'b1;
        sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
        wait_instr();
        chk("latency", 32'(instr_cyc - fetch_cyc), 32'd2);
        t_first = instr_cyc;
        wait_instr();
        chk("throughput", 32'(instr_cyc - t_first), 32'd3);
        wait_instr();

        // Backpressure in OUT
        bus.instr_ready = 1'b0;
        sb.push_back(32'hC);
        wait_instr();
        held_instr = mem_word(32'hC);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'b0, bus.instr_valid}, 32'd1);
            chk("bp_instr_pc", bus.instr_pc, 32'hC);
            chk("bp_instr", bus.instr, held_instr);
            chk("bp_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
            @(negedge clk);
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        wait_fetch(32'h10);

        // Redirect while holding an instruction in OUT
        bus.instr_ready = 1'b0;
        sb.push_back(32'h10);
        wait_instr();
        bus.pc_src = 1'b1; bus.pc_target = 32'h100; bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.pc_src = 1'b0;
        chk("kill_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
        wait_fetch(32'h100);
        sb.push_back(32'h100);
        wait_instr();

        // Redirect in WAIT with a 3-cycle response: stale word must be dropped
        lat = 3;
        wait_fetch(32'h104);
        @(negedge clk);
        bus.pc_src = 1'b1; bus.pc_target = 32'h200;
        @(negedge clk);
        bus.pc_src = 1'b0;
        lat = 1;
        chk("drop_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        chk("drop_no_instr", {31'b0, bus.instr_valid}, 32'd0);
        sb.push_back(32'h200);
        wait_fetch(32'h200);
        wait_instr();

        // Redirect while a request is stalled, to the wrap address
        bus.imem_req_ready = 1'b0;
        @(negedge clk);
        chk("stall_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        chk("stall_addr", bus.imem_addr, 32'h204);
        bus.pc_src = 1'b1; bus.pc_target = 32'hFFFF_FFFC;
        @(negedge clk);
        bus.pc_src = 1'b0;
        chk("stall_redirect_addr", bus.imem_addr, 32'hFFFF_FFFC);
        bus.imem_req_ready = 1'b1;
        sb.push_back(32'hFFFF_FFFC);
        wait_instr();
        wait_fetch(32'h0);
        sb.push_back(32'h0);
        wait_instr();

        // Reset asserted while a fetch is outstanding
        lat = 3;
        wait_fetch(32'h4);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("midrst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        chk("midrst_instr", bus.instr, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1; lat = 1;
        @(negedge clk);
        wait_fetch(32'h0);
        sb.push_back(32'h0);
        wait_instr();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
